tt_wokwi_434917577229968385_core: RTL and testbench

- Tiny Tapeout user tile: a 4-bit hexadecimal up/down counter driving a seven-segment display.
- Supports a programmable clock prescaler, synchronous parallel load, and a wrap (carry/borrow) flag.
- Sits directly behind the standard Tiny Tapeout tile pins: ui/uo/uio buses, ena, clk and reset.

---
 rtl/tt_wokwi_434917577229968385_core.sv | 66 ++++++
 tb/tb_tt_wokwi_434917577229968385_core.sv | 87 ++++++++
 2 files changed

// File: rtl/tt_wokwi_434917577229968385_core.sv
// tt_wokwi_434917577229968385_core: prescaled hex up/down counter with load, wrap pulse and seven-segment output
module tt_wokwi_434917577229968385_core #(
  parameter int PRESCALE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [PRESCALE_W-1:0] pre;
  logic [3:0] count;
  logic       wrap;
  logic [6:0] seg;
  logic       tick;
  logic       unused;
  assign unused = &{1'b0, uio_in};
  assign tick = ena & (ui_in[3] | (&pre));
  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pre   <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else if (!ena) begin
      wrap <= 1'b0;
    end else begin
      pre <= pre + 1'b1;
      if (ui_in[2]) begin
        count <= ui_in[7:4];
        wrap  <= 1'b0;
      end else if (tick & ui_in[0]) begin
        count <= ui_in[1] ? count - 4'd1 : count + 4'd1;
        wrap  <= ui_in[1] ? (count == 4'h0) : (count == 4'hF);
      end else begin
        wrap <= 1'b0;
      end
    end
  end
  always_comb begin
    case (count)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
  assign uo_out  = {wrap, seg};
  assign uio_out = {4'b0000, count};
  assign uio_oe  = 8'h0F;
endmodule

// File: tb/tb_tt_wokwi_434917577229968385_core.sv
// tb_tt_wokwi_434917577229968385_core: directed vector table plus reset and slow-mode sequences
module tb_tt_wokwi_434917577229968385_core;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  tt_wokwi_434917577229968385_core #(.PRESCALE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uo;
    logic [7:0] uio;
  } vec_t;
  vec_t v[$];
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    v.push_back('{1'b1, 1'b0, 8'h00, 8'h3F, 8'h00});
    v.push_back('{1'b1, 1'b0, 8'h00, 8'h3F, 8'h00});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'h06, 8'h01});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'h5B, 8'h02});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'h4F, 8'h03});
    v.push_back('{1'b0, 1'b1, 8'hF4, 8'h71, 8'h0F});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'hBF, 8'h00});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'h06, 8'h01});
    v.push_back('{1'b0, 1'b1, 8'h04, 8'h3F, 8'h00});
    v.push_back('{1'b0, 1'b1, 8'h0B, 8'hF1, 8'h0F});
    v.push_back('{1'b0, 1'b1, 8'h0B, 8'h79, 8'h0E});
    for (int i = 0; i < 10; i++) v.push_back('{1'b0, 1'b0, 8'h0D, 8'h79, 8'h0E});
    v.push_back('{1'b0, 1'b0, 8'h54, 8'h79, 8'h0E});
    v.push_back('{1'b0, 1'b1, 8'h54, 8'h6D, 8'h05});
    v.push_back('{1'b0, 1'b1, 8'h0A, 8'h6D, 8'h05});
    v.push_back('{1'b0, 1'b1, 8'hAD, 8'h77, 8'h0A});
    v.push_back('{1'b0, 1'b1, 8'h04, 8'h3F, 8'h00});
    v.push_back('{1'b0, 1'b1, 8'h0B, 8'hF1, 8'h0F});
    v.push_back('{1'b0, 1'b0, 8'h0B, 8'h71, 8'h0F});
    v.push_back('{1'b0, 1'b1, 8'hF4, 8'h71, 8'h0F});
    v.push_back('{1'b0, 1'b1, 8'h09, 8'hBF, 8'h00});
    v.push_back('{1'b0, 1'b1, 8'h08, 8'h3F, 8'h00});
    for (int d = 0; d < 16; d++) begin
      logic [3:0] n;
      n = 4'(d);
      v.push_back('{1'b0, 1'b1, {n, 4'h4}, {1'b0, seg_tab[d]}, {4'h0, n}});
    end
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rst; ena = v[i].ena; ui_in = v[i].ui; uio_in = 8'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_uo", i), uo_out, v[i].uo);
      chk($sformatf("vec%0d_uio", i), uio_out, v[i].uio);
      chk($sformatf("vec%0d_oe", i), uio_oe, 8'h0F);
    end
    @(negedge clk);
    ena = 1'b1; ui_in = 8'h54;
    @(posedge clk);
    #1;
    chk("pre_async_load5", uio_out, 8'h05);
    #2 rst_n = 1'b1;
    #1;
    chk("async_rst_uio", uio_out, 8'h00);
    chk("async_rst_uo", uo_out, 8'h3F);
    @(negedge clk);
    rst_n = 1'b0; ui_in = 8'h01;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("slow_edge%0d", k), uio_out, 8'(k / 16));
    end
    chk("slow_final_uo", uo_out, 8'h5B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
